// File: rtl/hazard_stall_if.sv
// rtl/hazard_stall_if.sv - hazard/stall controller signal bundle
// master = pipeline side driving hazard inputs, slave = controller.
interface hazard_stall_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             idex_mem_read;
  logic [REG_W-1:0] idex_rt;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_uses_rt;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             stall_active;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken, mem_busy,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, stall_active, stall_cycles
  );

  modport slave (
    input  idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken, mem_busy,
    output pc_write, ifid_write, idex_bubble, ifid_flush, stall_active, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch-flush / memory-wait stall sequencer
// Mealy outputs; MWAIT remembers the interrupted state and resumes it when memory frees.
module hazard_stall_ctrl #(
  parameter int REG_W      = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  hazard_stall_if.slave bus
);
  localparam int                CW       = $clog2(LOAD_STALL) + 1;
  localparam logic [CW-1:0]     CNT_INIT = CW'(LOAD_STALL - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [REG_W-1:0]  REG_ZERO = '0;

  typedef enum logic [1:0] {RUN, LSTALL, MWAIT} state_t;

  state_t           state, state_nx, ret_state, ret_nx, eval_state;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [CNT_W-1:0] stall_cycles;
  logic             lu;
  logic             pc_write, ifid_write, idex_bubble, ifid_flush, stall_active;

  assign lu = bus.idex_mem_read && (bus.idex_rt != REG_ZERO) &&
              ((bus.idex_rt == bus.ifid_rs) ||
               (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      ret_state    <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      cnt       <= cnt_nx;
      if (stall_active && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    ret_nx      = ret_state;
    cnt_nx      = cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    // Leaving MWAIT behaves exactly like the state that was interrupted.
    eval_state  = (state == MWAIT) ? ret_state : state;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (bus.mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_nx   = MWAIT;
      if (state != MWAIT)
        ret_nx = state;
    end else if (bus.branch_taken) begin
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      state_nx    = RUN;
      cnt_nx      = '0;
    end else if (eval_state == LSTALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      cnt_nx      = cnt - 1'b1;
      state_nx    = (cnt == CNT_ONE) ? RUN : LSTALL;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (LOAD_STALL > 1) begin
        state_nx = LSTALL;
        cnt_nx   = CNT_INIT;
      end else begin
        state_nx = RUN;
      end
    end else begin
      state_nx = RUN;
    end
  end

  assign stall_active     = !rst && !pc_write;
  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.stall_active = stall_active;
  assign bus.stall_cycles = stall_cycles;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
// Three instances share stimulus: LOAD_STALL=1, LOAD_STALL=3, and LOAD_STALL=2 with CNT_W=4.
module tb_hazard_stall_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       mr, urt, bt, mb;
  logic [4:0] drt, rs, rt;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  hazard_stall_if #(.REG_W(5), .CNT_W(16)) b1 ();
  hazard_stall_if #(.REG_W(5), .CNT_W(16)) b3 ();
  hazard_stall_if #(.REG_W(5), .CNT_W(4))  b4 ();

  hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL(1), .CNT_W(16)) u_ls1 (.clk(clk), .rst(rst), .bus(b1));
  hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL(3), .CNT_W(16)) u_ls3 (.clk(clk), .rst(rst), .bus(b3));
  hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL(2), .CNT_W(4))  u_sat (.clk(clk), .rst(rst), .bus(b4));

  assign b1.idex_mem_read = mr;  assign b3.idex_mem_read = mr;  assign b4.idex_mem_read = mr;
  assign b1.idex_rt       = drt; assign b3.idex_rt       = drt; assign b4.idex_rt       = drt;
  assign b1.ifid_rs       = rs;  assign b3.ifid_rs       = rs;  assign b4.ifid_rs       = rs;
  assign b1.ifid_rt       = rt;  assign b3.ifid_rt       = rt;  assign b4.ifid_rt       = rt;
  assign b1.ifid_uses_rt  = urt; assign b3.ifid_uses_rt  = urt; assign b4.ifid_uses_rt  = urt;
  assign b1.branch_taken  = bt;  assign b3.branch_taken  = bt;  assign b4.branch_taken  = bt;
  assign b1.mem_busy      = mb;  assign b3.mem_busy      = mb;  assign b4.mem_busy      = mb;

  // o = {pc_write, ifid_write, idex_bubble, ifid_flush, stall_active}
  logic [4:0]  o  [3];
  logic [15:0] sc [3];
  assign o[0]  = {b1.pc_write, b1.ifid_write, b1.idex_bubble, b1.ifid_flush, b1.stall_active};
  assign o[1]  = {b3.pc_write, b3.ifid_write, b3.idex_bubble, b3.ifid_flush, b3.stall_active};
  assign o[2]  = {b4.pc_write, b4.ifid_write, b4.idex_bubble, b4.ifid_flush, b4.stall_active};
  assign sc[0] = b1.stall_cycles;
  assign sc[1] = b3.stall_cycles;
  assign sc[2] = {12'd0, b4.stall_cycles};

  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00101;
  localparam logic [4:0] O_WAIT  = 5'b00001;
  localparam logic [4:0] O_BR    = 5'b11110;
  localparam logic [4:0] O_RST   = 5'b00000;

  int ls_p  [3] = '{1, 3, 2};
  int max_p [3] = '{65535, 65535, 15};

  task automatic drive(input logic r, input logic m, input logic [4:0] d, input logic [4:0] s,
                       input logic [4:0] t, input logic u, input logic b, input logic busy);
    @(negedge clk);
    rst = r; mr = m; drt = d; rs = s; rt = t; urt = u; bt = b; mb = busy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 5'h1f, 5'h1f, 5'h1f, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (o[i] !== O_RST) begin
          n_fail++;
          $display("FAIL reset_outputs dut%0d cyc%0d got %b exp %b", i, c, o[i], O_RST);
        end
      end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (sc[i] !== 16'd0 || o[i] !== O_RUN) begin
        n_fail++;
        $display("FAIL reset_release dut%0d got sc=%0d o=%b exp sc=0 o=%b", i, sc[i], o[i], O_RUN);
      end
    end
  endtask

  task automatic test_load_use_rs();
    do_reset();
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (o[0] !== O_STALL) begin
      n_fail++;
      $display("FAIL lu_rs_stall got %b exp %b", o[0], O_STALL);
    end
    idle();
    n_tests++;
    if (o[0] !== O_RUN || sc[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_rs_resume got o=%b sc=%0d exp o=%b sc=1", o[0], sc[0], O_RUN);
    end
  endtask

  task automatic test_rt_gating();
    do_reset();
    drive(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (o[0] !== O_RUN) begin
      n_fail++;
      $display("FAIL rt_unused got %b exp %b", o[0], O_RUN);
    end
    drive(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o[0] !== O_STALL) begin
      n_fail++;
      $display("FAIL rt_used got %b exp %b", o[0], O_STALL);
    end
    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o[0] !== O_RUN) begin
      n_fail++;
      $display("FAIL r0_load got %b exp %b", o[0], O_RUN);
    end
  endtask

  task automatic test_long_stall();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, (k == 0), 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (o[1] !== O_STALL) begin
        n_fail++;
        $display("FAIL ls3_stall cyc%0d got %b exp %b", k, o[1], O_STALL);
      end
    end
    idle();
    n_tests++;
    if (o[1] !== O_RUN || sc[1] !== 16'd3) begin
      n_fail++;
      $display("FAIL ls3_resume got o=%b sc=%0d exp o=%b sc=3", o[1], sc[1], O_RUN);
    end
    do_reset();
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (o[1] !== O_BR) begin
      n_fail++;
      $display("FAIL ls3_branch got %b exp %b", o[1], O_BR);
    end
    idle();
    n_tests++;
    if (o[1] !== O_RUN || sc[1] !== 16'd1) begin
      n_fail++;
      $display("FAIL ls3_after_branch got o=%b sc=%0d exp o=%b sc=1", o[1], sc[1], O_RUN);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (o[1] !== O_WAIT) begin
        n_fail++;
        $display("FAIL mwait_hold cyc%0d got %b exp %b", k, o[1], O_WAIT);
      end
    end
    for (int k = 0; k < 2; k++) begin
      idle();
      n_tests++;
      if (o[1] !== O_STALL) begin
        n_fail++;
        $display("FAIL mwait_resume cyc%0d got %b exp %b", k, o[1], O_STALL);
      end
    end
    idle();
    n_tests++;
    if (o[1] !== O_RUN || sc[1] !== 16'd7) begin
      n_fail++;
      $display("FAIL mwait_total got o=%b sc=%0d exp o=%b sc=7", o[1], sc[1], O_RUN);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 20; k++) drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    n_tests++;
    if (sc[2] !== 16'd15 || sc[0] !== 16'd20) begin
      n_fail++;
      $display("FAIL sat_20 got sat=%0d wide=%0d exp sat=15 wide=20", sc[2], sc[0]);
    end
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    n_tests++;
    if (sc[2] !== 16'd15 || sc[0] !== 16'd23) begin
      n_fail++;
      $display("FAIL sat_hold got sat=%0d wide=%0d exp sat=15 wide=23", sc[2], sc[0]);
    end
  endtask

  // Reference: 'pend' = load bubbles still owed; a memory wait simply freezes it.
  task automatic test_random();
    int         pend [3];
    int         cnt  [3];
    logic       lu;
    logic [4:0] exp_o;
    do_reset();
    for (int i = 0; i < 3; i++) begin pend[i] = 0; cnt[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 59) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      lu = mr && (drt != 5'd0) && ((drt == rs) || (urt && (drt == rt)));
      for (int i = 0; i < 3; i++) begin
        if (rst)              exp_o = O_RST;
        else if (mb)          exp_o = O_WAIT;
        else if (bt)          exp_o = O_BR;
        else if (pend[i] > 0) exp_o = O_STALL;
        else if (lu)          exp_o = O_STALL;
        else                  exp_o = O_RUN;
        n_tests++;
        if (o[i] !== exp_o || sc[i] !== 16'(cnt[i])) begin
          n_fail++;
          $display("FAIL rand dut%0d cyc%0d got o=%b sc=%0d exp o=%b sc=%0d",
                   i, c, o[i], sc[i], exp_o, cnt[i]);
        end
        if (rst) begin
          pend[i] = 0;
          cnt[i]  = 0;
        end else begin
          if (!mb) begin
            if (bt)               pend[i] = 0;
            else if (pend[i] > 0) pend[i] = pend[i] - 1;
            else if (lu)          pend[i] = ls_p[i] - 1;
          end
          if (exp_o[0] && cnt[i] < max_p[i]) cnt[i] = cnt[i] + 1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; mr = 1'b0; drt = '0; rs = '0; rt = '0; urt = 1'b0; bt = 1'b0; mb = 1'b0;
    test_reset();
    test_load_use_rs();
    test_rt_gating();
    test_long_stall();
    test_mem_wait();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
